// File: rtl/voice_pkg.sv
// Shared types for the polyphonic voice allocator: voice state encoding and sizing constants.
package voice_pkg;
  typedef enum logic [1:0] {
    V_IDLE    = 2'd0,
    V_HELD    = 2'd1,
    V_RELEASE = 2'd2
  } voice_state_t;

  localparam int KEY_IDX_W  = 4;
  localparam int MAX_VOICES = 8;
endpackage

// File: rtl/voice_slot.sv
// One voice slot: IDLE/HELD/RELEASE state machine, release-tail countdown and saturating age.
module voice_slot
  import voice_pkg::*;
#(
  parameter int RELEASE_CYCLES = 1024,
  parameter int AGE_W          = 16
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 alloc_in,
  input  logic [KEY_IDX_W-1:0] alloc_key_in,
  input  logic                 key_gate_in,
  output voice_state_t         state_out,
  output logic [KEY_IDX_W-1:0] key_out,
  output logic [AGE_W-1:0]     age_out,
  output logic                 trig_out
);
  localparam int REL_W = (RELEASE_CYCLES > 1) ? $clog2(RELEASE_CYCLES) : 1;

  voice_state_t         state_q, state_d;
  logic [KEY_IDX_W-1:0] key_q, key_d;
  logic [AGE_W-1:0]     age_q, age_d;
  logic [REL_W-1:0]     rel_q, rel_d;
  logic                 trig_q, trig_d;

  // Allocation has priority over the gate-drop transition in the same cycle.
  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    age_d   = age_q;
    rel_d   = rel_q;
    trig_d  = 1'b0;
    if (alloc_in) begin
      state_d = V_HELD;
      key_d   = alloc_key_in;
      age_d   = '0;
      rel_d   = '0;
      trig_d  = 1'b1;
    end else begin
      if ((state_q != V_IDLE) && (age_q != '1)) age_d = age_q + 1'b1;
      case (state_q)
        V_HELD: begin
          if (!key_gate_in) begin
            state_d = V_RELEASE;
            rel_d   = REL_W'(RELEASE_CYCLES - 1);
          end
        end
        V_RELEASE: begin
          if (rel_q == '0) state_d = V_IDLE;
          else             rel_d   = rel_q - 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= V_IDLE;
      key_q   <= '0;
      age_q   <= '0;
      rel_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      age_q   <= age_d;
      rel_q   <= rel_d;
      trig_q  <= trig_d;
    end
  end

  assign state_out = state_q;
  assign key_out   = key_q;
  assign age_out   = age_q;
  assign trig_out  = trig_q;
endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: pending-key mask, lowest-key service and voice selection.
// Define VOICE_STEAL_EN to steal the oldest HELD voice instead of dropping when none is free.
module voice_allocator
  import voice_pkg::*;
#(
  parameter int NUM_KEYS       = 12,
  parameter int NUM_VOICES     = 4,
  parameter int RELEASE_CYCLES = 1024,
  parameter int AGE_W          = 16
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic [NUM_KEYS-1:0]             gate_in,
  input  logic [NUM_KEYS-1:0]             trigger_in,
  output logic [NUM_VOICES*KEY_IDX_W-1:0] voice_key_out,
  output logic [NUM_VOICES-1:0]           voice_gate_out,
  output logic [NUM_VOICES-1:0]           voice_trig_out,
  output logic [NUM_VOICES-1:0]           voice_active_out,
  output logic                            drop_out
);
  logic [NUM_KEYS-1:0]   pend_q, pend_d;
  logic                  drop_q, drop_d;
  logic [NUM_KEYS-1:0]   pend_all, svc_hot;
  logic                  svc_valid, svc_gate;
  logic [KEY_IDX_W-1:0]  svc_key;
  logic [NUM_VOICES-1:0] alloc_vec, key_gate;
  logic [NUM_VOICES-1:0] hit_sel, idle_sel, rel_sel, held_sel;
  logic                  hit_found, idle_found, rel_found, held_found;
  logic [AGE_W-1:0]      rel_age, held_age;

  voice_state_t          st_v  [NUM_VOICES];
  logic [KEY_IDX_W-1:0]  key_v [NUM_VOICES];
  logic [AGE_W-1:0]      age_v [NUM_VOICES];

  // Lowest set bit of the pending mask is the one key serviced this cycle.
  always_comb begin
    pend_all  = pend_q | trigger_in;
    svc_hot   = pend_all & ~(pend_all - 1'b1);
    svc_valid = |pend_all;
    svc_gate  = |(svc_hot & gate_in);
    pend_d    = pend_all & ~svc_hot;
    svc_key   = '0;
    for (int k = 0; k < NUM_KEYS; k++) begin
      if (svc_hot[k]) svc_key = KEY_IDX_W'(k);
    end
  end

  always_comb begin
    hit_found  = 1'b0;
    idle_found = 1'b0;
    rel_found  = 1'b0;
    held_found = 1'b0;
    hit_sel    = '0;
    idle_sel   = '0;
    rel_sel    = '0;
    held_sel   = '0;
    rel_age    = '0;
    held_age   = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (!hit_found && (st_v[v] != V_IDLE) && (key_v[v] == svc_key)) begin
        hit_found  = 1'b1;
        hit_sel[v] = 1'b1;
      end
      if (!idle_found && (st_v[v] == V_IDLE)) begin
        idle_found  = 1'b1;
        idle_sel[v] = 1'b1;
      end
      // Strict compare keeps the lowest index on equal ages.
      if ((st_v[v] == V_RELEASE) && (!rel_found || (age_v[v] > rel_age))) begin
        rel_found  = 1'b1;
        rel_age    = age_v[v];
        rel_sel    = '0;
        rel_sel[v] = 1'b1;
      end
      if ((st_v[v] == V_HELD) && (!held_found || (age_v[v] > held_age))) begin
        held_found  = 1'b1;
        held_age    = age_v[v];
        held_sel    = '0;
        held_sel[v] = 1'b1;
      end
    end

    alloc_vec = '0;
    drop_d    = 1'b0;
    if (svc_valid && svc_gate) begin
      if (hit_found)       alloc_vec = hit_sel;
      else if (idle_found) alloc_vec = idle_sel;
      else if (rel_found)  alloc_vec = rel_sel;
      else begin
`ifdef VOICE_STEAL_EN
        alloc_vec = held_sel;
`else
        drop_d    = 1'b1;
`endif
      end
    end
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      key_gate[v] = 1'b0;
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (key_v[v] == KEY_IDX_W'(k)) key_gate[v] = gate_in[k];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      pend_q <= '0;
      drop_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      drop_q <= drop_d;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    voice_slot #(
      .RELEASE_CYCLES(RELEASE_CYCLES),
      .AGE_W         (AGE_W)
    ) u_slot (
      .clk_in      (clk_in),
      .rst_in      (rst_in),
      .alloc_in    (alloc_vec[v]),
      .alloc_key_in(svc_key),
      .key_gate_in (key_gate[v]),
      .state_out   (st_v[v]),
      .key_out     (key_v[v]),
      .age_out     (age_v[v]),
      .trig_out    (voice_trig_out[v])
    );

    assign voice_key_out[v*KEY_IDX_W +: KEY_IDX_W] = key_v[v];
    assign voice_gate_out[v]   = (st_v[v] == V_HELD);
    assign voice_active_out[v] = (st_v[v] != V_IDLE);
  end

  assign drop_out = drop_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Scenario bench for voice_allocator with a scoreboard of expected voice starts and drops.
module tb_voice_allocator;
  localparam int NK = 12;
  localparam int NV = 4;
  localparam int RC = 16;
  localparam int DROP_V = 99;

  logic          clk;
  logic          rst_in;
  logic [NK-1:0] gate_in;
  logic [NK-1:0] trigger_in;
  logic [NV*4-1:0] voice_key_out;
  logic [NV-1:0] voice_gate_out;
  logic [NV-1:0] voice_trig_out;
  logic [NV-1:0] voice_active_out;
  logic          drop_out;

  typedef struct {
    int voice;
    int key;
  } exp_t;

  exp_t sb_q[$];
  int   checks;
  int   errors;

  voice_allocator #(
    .NUM_KEYS      (NK),
    .NUM_VOICES    (NV),
    .RELEASE_CYCLES(RC),
    .AGE_W         (16)
  ) dut (
    .clk_in          (clk),
    .rst_in          (rst_in),
    .gate_in         (gate_in),
    .trigger_in      (trigger_in),
    .voice_key_out   (voice_key_out),
    .voice_gate_out  (voice_gate_out),
    .voice_trig_out  (voice_trig_out),
    .voice_active_out(voice_active_out),
    .drop_out        (drop_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and retire any voice start / drop the DUT reports against the queue.
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    if (!rst_in) begin
      for (int v = 0; v < NV; v++) begin
        if (voice_trig_out[v]) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected_trig voice=%0d key=%0d queue empty", v, voice_key_out[4*v +: 4]);
          end else begin
            e = sb_q.pop_front();
            if (e.voice !== v || e.key !== int'(voice_key_out[4*v +: 4])) begin
              errors++;
              $display("FAIL sb_trig got voice=%0d key=%0d expected voice=%0d key=%0d",
                       v, voice_key_out[4*v +: 4], e.voice, e.key);
            end
          end
        end
      end
      if (drop_out) begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL sb_unexpected_drop queue empty");
        end else begin
          e = sb_q.pop_front();
          if (e.voice !== DROP_V) begin
            errors++;
            $display("FAIL sb_drop got drop expected voice=%0d key=%0d", e.voice, e.key);
          end
        end
      end
    end
  endtask

  task automatic press(input int k, input int v);
    sb_q.push_back('{voice: v, key: k});
    gate_in[k]    = 1'b1;
    trigger_in[k] = 1'b1;
    tick();
    trigger_in[k] = 1'b0;
  endtask

  task automatic release_all_and_idle();
    gate_in = '0;
    repeat (RC + 3) tick();
    checks++;
    if (voice_active_out !== '0) begin
      errors++;
      $display("FAIL idle_after_release active=%b expected=%b", voice_active_out, 4'b0000);
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    gate_in = '0;
    trigger_in = '0;
    #2 rst_in = 1'b1;
    #1;
    checks++;
    if ({voice_key_out, voice_gate_out, voice_trig_out, voice_active_out, drop_out} !== '0) begin
      errors++;
      $display("FAIL reset_outputs key=%h gate=%b trig=%b act=%b drop=%b expected all zero",
               voice_key_out, voice_gate_out, voice_trig_out, voice_active_out, drop_out);
    end
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_single_release();
    press(3, 0);
    checks++;
    if (voice_trig_out !== 4'b0001 || voice_gate_out !== 4'b0001 || voice_key_out[3:0] !== 4'd3) begin
      errors++;
      $display("FAIL single_alloc trig=%b gate=%b key0=%0d expected 0001 0001 3",
               voice_trig_out, voice_gate_out, voice_key_out[3:0]);
    end
    tick();
    checks++;
    if (voice_trig_out !== 4'b0000 || voice_gate_out !== 4'b0001) begin
      errors++;
      $display("FAIL single_hold trig=%b gate=%b expected 0000 0001", voice_trig_out, voice_gate_out);
    end
    gate_in[3] = 1'b0;
    tick();
    checks++;
    if (voice_gate_out !== 4'b0000 || voice_active_out !== 4'b0001) begin
      errors++;
      $display("FAIL release_start gate=%b act=%b expected 0000 0001", voice_gate_out, voice_active_out);
    end
    repeat (RC - 1) tick();
    checks++;
    if (voice_active_out !== 4'b0001) begin
      errors++;
      $display("FAIL release_tail act=%b expected 0001", voice_active_out);
    end
    tick();
    checks++;
    if (voice_active_out !== 4'b0000) begin
      errors++;
      $display("FAIL release_end act=%b expected 0000", voice_active_out);
    end
  endtask

  task automatic test_multi();
    for (int k = 0; k < 3; k++) sb_q.push_back('{voice: k, key: k});
    gate_in[2:0]    = 3'b111;
    trigger_in[2:0] = 3'b111;
    tick();
    trigger_in = '0;
    trigger_in[2] = 1'b1;
    checks++;
    if (voice_trig_out !== 4'b0001 || voice_key_out[3:0] !== 4'd0) begin
      errors++;
      $display("FAIL multi_first trig=%b key0=%0d expected 0001 0", voice_trig_out, voice_key_out[3:0]);
    end
    tick();
    trigger_in = '0;
    checks++;
    if (voice_trig_out !== 4'b0010 || voice_key_out[7:4] !== 4'd1) begin
      errors++;
      $display("FAIL multi_second trig=%b key1=%0d expected 0010 1", voice_trig_out, voice_key_out[7:4]);
    end
    tick();
    checks++;
    if (voice_trig_out !== 4'b0100 || voice_key_out[11:8] !== 4'd2) begin
      errors++;
      $display("FAIL multi_third trig=%b key2=%0d expected 0100 2", voice_trig_out, voice_key_out[11:8]);
    end
    tick();
    checks++;
    if (voice_trig_out !== 4'b0000 || voice_gate_out !== 4'b0111) begin
      errors++;
      $display("FAIL multi_settle trig=%b gate=%b expected 0000 0111", voice_trig_out, voice_gate_out);
    end
    release_all_and_idle();
  endtask

  task automatic test_retrig_release();
    press(5, 0);
    press(3, 1);
    gate_in[3] = 1'b0;
    repeat (3) tick();
    press(3, 1);
    checks++;
    if (voice_trig_out !== 4'b0010 || voice_gate_out !== 4'b0011 || voice_key_out[7:4] !== 4'd3) begin
      errors++;
      $display("FAIL retrig_reuse trig=%b gate=%b key1=%0d expected 0010 0011 3",
               voice_trig_out, voice_gate_out, voice_key_out[7:4]);
    end
    release_all_and_idle();
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) press(k, k);
`ifdef VOICE_STEAL_EN
    press(4, 0);
    checks++;
    if (voice_key_out !== 16'h3214 || voice_trig_out !== 4'b0001 || drop_out !== 1'b0) begin
      errors++;
      $display("FAIL steal keys=%h trig=%b drop=%b expected 3214 0001 0", voice_key_out, voice_trig_out, drop_out);
    end
`else
    press(4, DROP_V);
    checks++;
    if (drop_out !== 1'b1 || voice_key_out !== 16'h3210 || voice_trig_out !== 4'b0000) begin
      errors++;
      $display("FAIL drop keys=%h trig=%b drop=%b expected 3210 0000 1", voice_key_out, voice_trig_out, drop_out);
    end
`endif
    tick();
    checks++;
    if (drop_out !== 1'b0 || voice_gate_out !== 4'b1111) begin
      errors++;
      $display("FAIL full_after drop=%b gate=%b expected 0 1111", drop_out, voice_gate_out);
    end
  endtask

  task automatic test_release_pick();
    gate_in[1] = 1'b0;
    gate_in[2] = 1'b0;
    repeat (2) tick();
    press(6, 1);
    checks++;
    if (voice_trig_out !== 4'b0010 || voice_key_out[7:4] !== 4'd6 || voice_gate_out !== 4'b1011) begin
      errors++;
      $display("FAIL release_pick trig=%b key1=%0d gate=%b expected 0010 6 1011",
               voice_trig_out, voice_key_out[7:4], voice_gate_out);
    end
    release_all_and_idle();
  endtask

  task automatic test_gate_low_discard();
    trigger_in[7] = 1'b1;
    tick();
    trigger_in = '0;
    tick();
    checks++;
    if (voice_trig_out !== 4'b0000 || drop_out !== 1'b0 || voice_active_out !== 4'b0000) begin
      errors++;
      $display("FAIL gate_low_discard trig=%b drop=%b act=%b expected 0000 0 0000",
               voice_trig_out, drop_out, voice_active_out);
    end
  endtask

  task automatic test_reset_mid();
    press(3, 0);
    #3 rst_in = 1'b1;
    #1;
    checks++;
    if ({voice_key_out, voice_gate_out, voice_trig_out, voice_active_out, drop_out} !== '0) begin
      errors++;
      $display("FAIL reset_mid key=%h gate=%b trig=%b act=%b drop=%b expected all zero",
               voice_key_out, voice_gate_out, voice_trig_out, voice_active_out, drop_out);
    end
    repeat (2) tick();
    rst_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (voice_trig_out !== 4'b0000 || voice_active_out !== 4'b0000) begin
        errors++;
        $display("FAIL reset_release cyc=%0d trig=%b act=%b expected 0000 0000",
                 i, voice_trig_out, voice_active_out);
      end
    end
    gate_in = '0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_release();
    test_multi();
    test_retrig_release();
    test_full();
    test_release_pick();
    test_gate_low_discard();
    test_reset_mid();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover pending=%0d expected 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
